// File: rtl/lockstep_pkg.sv
// lockstep_pkg -- shared definitions for the lockstep comparator.
//   state_e     : comparator FSM state encoding (IDLE/WARMUP/MONITOR/FAULT)
//   DEF_*       : parameter defaults used by lockstep_compare
//   ch_idx_w()  : width of a channel index, never less than one bit
package lockstep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DELAY    = 0;
    localparam int DEF_THRESH   = 1;
    localparam int DEF_CNT_W    = 8;

    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/lockstep_delay.sv
// lockstep_delay -- alignment pipeline for the reference (a) side.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous reset, active-low (clears every stage)
//   flush_i : synchronous flush, zeroes every stage so no stale data survives
//   d_i     : W-bit input word
//   q_o     : d_i delayed by exactly DELAY clocks (combinational pass-through when DELAY=0)
module lockstep_delay #(
    parameter int W     = 32,
    parameter int DELAY = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DELAY == 0) begin : g_bypass
            // No stages: clock, reset and flush have nothing to act on.
            logic unused_bypass;
            assign unused_bypass = clk_i ^ rst_i ^ flush_i;
            assign q_o = d_i;
        end else begin : g_pipe
            logic [DELAY-1:0][W-1:0] stage_reg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    stage_reg <= '0;
                end else if (flush_i) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg[0] <= d_i;
                    for (int i = 1; i < DELAY; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign q_o = stage_reg[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/lockstep_compare.sv
// lockstep_compare -- compares CHANNELS pairs of WIDTH-bit lockstep outputs.
// The a-side (reference) is aligned through DELAY register stages; b is used
// as-is. Comparison runs only in MONITOR/FAULT; a mismatching cycle bumps a
// saturating error counter, and reaching THRESH enters FAULT and raises a
// sticky alarm. The first mismatch since reset/clear is captured.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous reset, active-low
//   en_i         : comparison enable (0 returns the FSM to IDLE)
//   clr_i        : synchronous clear of counter, capture and fault
//   mask_i       : per-channel compare enable (1 = compared)
//   a_i, b_i     : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   mismatch_o   : any unmasked channel differed in the previous compare cycle
//   err_cnt_o    : number of mismatching compare cycles (saturating)
//   fault_o      : sticky threshold alarm
//   first_vld_o  : capture registers hold a valid first mismatch
//   first_ch_o   : lowest mismatching channel of the first mismatch
//   first_a_o/b_o: aligned a and b values of that channel
//   state_o      : current FSM state
module lockstep_compare
    import lockstep_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DELAY    = DEF_DELAY,
    parameter int THRESH   = DEF_THRESH,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic [CHANNELS-1:0]           mask_i,
    input  logic [CHANNELS*WIDTH-1:0]     a_i,
    input  logic [CHANNELS*WIDTH-1:0]     b_i,
    output logic                          mismatch_o,
    output logic [CNT_W-1:0]              err_cnt_o,
    output logic                          fault_o,
    output logic                          first_vld_o,
    output logic [ch_idx_w(CHANNELS)-1:0] first_ch_o,
    output logic [WIDTH-1:0]              first_a_o,
    output logic [WIDTH-1:0]              first_b_o,
    output logic [1:0]                    state_o
);

    localparam int               CH_W        = ch_idx_w(CHANNELS);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] THRESH_V    = CNT_W'(THRESH);
    // WARMUP lasts DELAY cycles (at least one), counted 0..WARM_LAST.
    localparam logic [2:0]       WARM_LAST_V = 3'((DELAY > 0) ? DELAY - 1 : 0);

    // ---------------------------------------------------------------
    // a-side alignment; flushed whenever comparison is (re)started so
    // values from before a clear or disable are never compared.
    // ---------------------------------------------------------------
    logic                      flush;
    logic [CHANNELS*WIDTH-1:0] a_al;

    assign flush = clr_i | ~en_i;

    lockstep_delay #(
        .W     (CHANNELS * WIDTH),
        .DELAY (DELAY)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .d_i     (a_i),
        .q_o     (a_al)
    );

    // ---------------------------------------------------------------
    // Per-channel compare
    // ---------------------------------------------------------------
    logic [CHANNELS-1:0] ch_mis;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign ch_mis[gi] = mask_i[gi] &
                                (a_al[gi*WIDTH +: WIDTH] != b_i[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // Lowest-indexed mismatching channel: scan downward so the last hit wins.
    logic [CH_W-1:0]  hit_ch;
    logic [WIDTH-1:0] hit_a;
    logic [WIDTH-1:0] hit_b;

    always_comb begin
        hit_ch = '0;
        hit_a  = '0;
        hit_b  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ch_mis[k]) begin
                hit_ch = CH_W'(k);
                hit_a  = a_al[k*WIDTH +: WIDTH];
                hit_b  = b_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    state_e           state_reg;
    logic [2:0]       warm_reg;
    logic             mis_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             fault_reg;
    logic             vld_reg;
    logic [CH_W-1:0]  ch_reg;
    logic [WIDTH-1:0] fa_reg;
    logic [WIDTH-1:0] fb_reg;
    logic             cmp_active;
    logic             mis_hit;

    // A clear in the same cycle wins over a mismatch, so it suppresses compare.
    always_comb begin
        cmp_active = en_i && !clr_i &&
                     (state_reg == ST_MONITOR || state_reg == ST_FAULT);
        mis_hit    = cmp_active && (|ch_mis);
        cnt_next   = cnt_reg;
        if (clr_i) begin
            cnt_next = '0;
        end else if (mis_hit && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            warm_reg  <= '0;
            mis_reg   <= 1'b0;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
            vld_reg   <= 1'b0;
            ch_reg    <= '0;
            fa_reg    <= '0;
            fb_reg    <= '0;
        end else begin
            mis_reg <= mis_hit;
            cnt_reg <= cnt_next;

            // First-mismatch capture
            if (clr_i) begin
                vld_reg <= 1'b0;
                ch_reg  <= '0;
                fa_reg  <= '0;
                fb_reg  <= '0;
            end else if (mis_hit && !vld_reg) begin
                vld_reg <= 1'b1;
                ch_reg  <= hit_ch;
                fa_reg  <= hit_a;
                fb_reg  <= hit_b;
            end

            // FSM; the fault alarm is only released by clear or reset.
            if (clr_i) begin
                fault_reg <= 1'b0;
            end

            if (!en_i) begin
                state_reg <= ST_IDLE;
                warm_reg  <= '0;
            end else if (clr_i) begin
                state_reg <= ST_WARMUP;
                warm_reg  <= '0;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_WARMUP;
                        warm_reg  <= '0;
                    end
                    ST_WARMUP: begin
                        if (warm_reg == WARM_LAST_V) begin
                            state_reg <= ST_MONITOR;
                        end else begin
                            warm_reg <= warm_reg + 3'd1;
                        end
                    end
                    ST_MONITOR: begin
                        // Use the post-increment count so FAULT and the alarm
                        // appear on the same edge the count reaches THRESH.
                        if (cnt_next >= THRESH_V) begin
                            state_reg <= ST_FAULT;
                            fault_reg <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        state_reg <= ST_FAULT;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mismatch_o  = mis_reg;
    assign err_cnt_o   = cnt_reg;
    assign fault_o     = fault_reg;
    assign first_vld_o = vld_reg;
    assign first_ch_o  = ch_reg;
    assign first_a_o   = fa_reg;
    assign first_b_o   = fb_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_lockstep_compare.sv
// tb_lockstep_compare -- randomized plus directed stimulus for lockstep_compare,
// checked every cycle against a behavioural model. Two instances share the
// inputs: one with an 8-bit counter, one with a 2-bit counter for saturation.
module tb_lockstep_compare;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int D  = 2;
    localparam int TH = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          clr_i;
    logic [CH-1:0] mask_i;
    logic [31:0]   a_i;
    logic [31:0]   b_i;

    logic          mis_a, flt_a, vld_a;
    logic [7:0]    cnt_a;
    logic [1:0]    ch_a, st_a;
    logic [W-1:0]  fa_a, fb_a;

    logic          mis_s, flt_s, vld_s;
    logic [1:0]    cnt_s;
    logic [1:0]    ch_s, st_s;
    logic [W-1:0]  fa_s, fb_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk_i = ~clk_i;

    lockstep_compare #(.WIDTH(W), .CHANNELS(CH), .DELAY(D), .THRESH(TH), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .mask_i(mask_i),
        .a_i(a_i), .b_i(b_i), .mismatch_o(mis_a), .err_cnt_o(cnt_a), .fault_o(flt_a),
        .first_vld_o(vld_a), .first_ch_o(ch_a), .first_a_o(fa_a), .first_b_o(fb_a),
        .state_o(st_a)
    );

    lockstep_compare #(.WIDTH(W), .CHANNELS(CH), .DELAY(D), .THRESH(TH), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i), .mask_i(mask_i),
        .a_i(a_i), .b_i(b_i), .mismatch_o(mis_s), .err_cnt_o(cnt_s), .fault_o(flt_s),
        .first_vld_o(vld_s), .first_ch_o(ch_s), .first_a_o(fa_s), .first_b_o(fb_s),
        .state_o(st_s)
    );

    // ---------------- behavioural model ----------------
    // m_q holds the a-values the aligned side will present, oldest first.
    logic [31:0] m_q[$];
    int          m_state, m_warm, m_cnt8, m_cnt2, m_ch;
    bit          m_mis, m_fault, m_vld;
    logic [7:0]  m_fa, m_fb;

    task automatic model_reset();
        m_state = 0; m_warm = 0; m_cnt8 = 0; m_cnt2 = 0; m_ch = 0;
        m_mis = 0; m_fault = 0; m_vld = 0; m_fa = 0; m_fb = 0;
        m_q.delete();
        repeat (D) m_q.push_back(32'h0);
    endtask

    task automatic model_step();
        logic [31:0] al;
        bit cmp, any;
        int ch;
        al  = m_q[0];
        cmp = en_i && !clr_i && (m_state == 2 || m_state == 3);
        any = 0;
        ch  = 0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (mask_i[k] && (al[k*W +: W] != b_i[k*W +: W])) begin
                any = 1;
                ch  = k;
            end
        end
        m_mis = cmp && any;
        if (clr_i) begin
            m_cnt8 = 0; m_cnt2 = 0; m_fault = 0; m_vld = 0; m_ch = 0; m_fa = 0; m_fb = 0;
        end else if (m_mis) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_vld) begin
                m_vld = 1; m_ch = ch; m_fa = al[ch*W +: W]; m_fb = b_i[ch*W +: W];
            end
        end
        if (!en_i) begin
            m_state = 0;
        end else if (clr_i || m_state == 0) begin
            m_state = 1;
            m_warm  = 0;
        end else if (m_state == 1) begin
            m_warm++;
            if (m_warm >= ((D == 0) ? 1 : D)) m_state = 2;
        end else if (m_state == 2 && m_cnt8 >= TH) begin
            m_state = 3;
            m_fault = 1;
        end
        if (!en_i || clr_i) begin
            m_q.delete();
            repeat (D) m_q.push_back(32'h0);
        end else begin
            m_q.push_back(a_i);
            void'(m_q.pop_front());
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_set(input string p, input logic mis, input logic [7:0] cnt,
                             input logic flt, input logic vld, input logic [1:0] ch,
                             input logic [7:0] fa, input logic [7:0] fb, input logic [1:0] st,
                             input int exp_cnt);
        check({p, "_mismatch"}, 64'(mis), 64'(m_mis));
        check({p, "_err_cnt"},  64'(cnt), 64'(exp_cnt));
        check({p, "_fault"},    64'(flt), 64'(m_fault));
        check({p, "_first_vld"},64'(vld), 64'(m_vld));
        check({p, "_first_ch"}, 64'(ch),  64'(m_ch));
        check({p, "_first_a"},  64'(fa),  64'(m_fa));
        check({p, "_first_b"},  64'(fb),  64'(m_fb));
        check({p, "_state"},    64'(st),  64'(m_state));
    endtask

    task automatic compare_all();
        check_set("main", mis_a, cnt_a, flt_a, vld_a, ch_a, fa_a, fb_a, st_a, m_cnt8);
        check_set("sat", mis_s, {6'd0, cnt_s}, flt_s, vld_s, ch_s, fa_s, fb_s, st_s, m_cnt2);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        cyc++;
        compare_all();
        $display("cyc %0d en=%b clr=%b mask=%b a=%h b=%h -> mis=%b cnt=%0d/%0d st=%0d flt=%b vld=%b ch=%0d",
                 cyc, en_i, clr_i, mask_i, a_i, b_i, mis_a, cnt_a, cnt_s, st_a, flt_a, vld_a, ch_a);
    endtask

    // b follows the aligned a-side, with inj flipping chosen bits.
    task automatic drive(input bit en, input bit clr, input logic [3:0] mask, input logic [31:0] inj);
        en_i   = en;
        clr_i  = clr;
        mask_i = mask;
        a_i    = $urandom;
        b_i    = m_q[0] ^ inj;
        step();
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_main_outputs"}, {mis_a, cnt_a, flt_a, vld_a, ch_a, fa_a, fb_a, st_a}, 64'h0);
        check({p, "_sat_outputs"},  {mis_s, cnt_s, flt_s, vld_s, ch_s, fa_s, fb_s, st_s}, 64'h0);
    endtask

    initial begin
        logic [31:0] al;
        logic [7:0]  exp_a;
        rst_i = 1'b0; en_i = 1'b0; clr_i = 1'b0; mask_i = '0; a_i = '0; b_i = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b1;
        drive(0, 0, 4'hF, 0);

        // Identical streams: MONITOR three cycles after enable
        drive(1, 0, 4'hF, 0);
        drive(1, 0, 4'hF, 0);
        check("warmup_state", 64'(st_a), 64'd1);
        drive(1, 0, 4'hF, 0);
        check("monitor_after_3", 64'(st_a), 64'd2);
        repeat (97) drive(1, 0, 4'hF, 0);
        check("identical_err_cnt", 64'(cnt_a), 64'd0);
        check("identical_fault", 64'(flt_a), 64'd0);

        // Single-cycle corruption of channel 2
        al    = m_q[0];
        exp_a = al[23:16];
        drive(1, 0, 4'hF, 32'h0001_0000);
        check("ch2_mismatch_hi", 64'(mis_a), 64'd1);
        check("ch2_err_cnt", 64'(cnt_a), 64'd1);
        check("ch2_first_vld", 64'(vld_a), 64'd1);
        check("ch2_first_ch", 64'(ch_a), 64'd2);
        check("ch2_first_a", 64'(fa_a), 64'(exp_a));
        check("ch2_first_b", 64'(fb_a), 64'(exp_a ^ 8'h01));
        drive(1, 0, 4'hF, 0);
        check("ch2_mismatch_lo", 64'(mis_a), 64'd0);

        // Channels 1 and 3 together count once, lowest channel captured
        drive(1, 1, 4'hF, 0);
        repeat (2) drive(1, 0, 4'hF, 0);
        drive(1, 0, 4'hF, 32'h8000_0200);
        check("dual_err_cnt", 64'(cnt_a), 64'd1);
        check("dual_first_ch", 64'(ch_a), 64'd1);

        // Three mismatching cycles reach FAULT; fault survives en_i=0
        drive(1, 1, 4'hF, 0);
        repeat (2) drive(1, 0, 4'hF, 0);
        repeat (3) drive(1, 0, 4'hF, 32'h0000_0010 << (8 * $urandom_range(0, 3)));
        check("thresh_fault", 64'(flt_a), 64'd1);
        check("thresh_state", 64'(st_a), 64'd3);
        repeat (3) drive(0, 0, 4'hF, 0);
        check("disabled_fault", 64'(flt_a), 64'd1);
        check("disabled_state", 64'(st_a), 64'd0);
        check("disabled_err_hold", 64'(cnt_a), 64'd3);

        // Masked channel ignored; clear beats a simultaneous mismatch
        drive(1, 1, 4'b1011, 0);
        check("clr_fault", 64'(flt_a), 64'd0);
        repeat (2) drive(1, 0, 4'b1011, 0);
        repeat (3) drive(1, 0, 4'b1011, 32'h0055_0000);
        check("masked_mismatch", 64'(mis_a), 64'd0);
        check("masked_err_cnt", 64'(cnt_a), 64'd0);
        drive(1, 0, 4'hF, 0);
        drive(1, 1, 4'hF, 32'h0000_0001);
        check("clr_prio_err_cnt", 64'(cnt_a), 64'd0);
        check("clr_prio_first_vld", 64'(vld_a), 64'd0);

        // Continuous mismatch: 2-bit counter saturates
        repeat (2) drive(1, 0, 4'hF, 0);
        repeat (8) drive(1, 0, 4'hF, 32'h0000_0100);
        check("sat_err_cnt", 64'(cnt_s), 64'd3);
        check("wide_err_cnt", 64'(cnt_a), 64'd8);

        // Asynchronous reset mid-run clears outputs without a clock edge
        #2 rst_i = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lockstep_compare.md
LOCKSTEP_COMPARE -- requirements
Module: lockstep_compare

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, bits per channel; CHANNELS, default 4, channel-pair count (1..16); DELAY, default 0, alignment stages applied to the a-side (0..7); THRESH, default 1, mismatch count that raises fault (1..2^CNT_W-1); CNT_W, default 8, error-counter width.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The ports SHALL be:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- en_i  in  1  comparison enable.
- clr_i  in  1  synchronous clear of counter, capture and fault.
- mask_i  in  CHANNELS  per-channel compare enable (1 = compared).
- a_i  in  CHANNELS*WIDTH  reference outputs; channel k at [k*WIDTH +: WIDTH].
- b_i  in  CHANNELS*WIDTH  outputs under check; same packing.
- mismatch_o  out  1  registered: any unmasked channel differed in the previous compare cycle.
- err_cnt_o  out  CNT_W  count of mismatching compare cycles.
- fault_o  out  1  sticky threshold alarm.
- first_vld_o  out  1  capture registers valid.
- first_ch_o  out  max(1,$clog2(CHANNELS))  channel of the first mismatch.
- first_a_o, first_b_o  out  WIDTH  aligned a and b values at the first mismatch.
- state_o  out  2  current FSM state encoding.

Function
REQ-004 The a-side SHALL pass through exactly DELAY register stages; with DELAY=0 the aligned a-side is a_i directly; b_i SHALL never be delayed.
REQ-005 The FSM SHALL have states IDLE=0, WARMUP=1, MONITOR=2 and FAULT=3.
REQ-006 Transitions:
- IDLE->WARMUP when en_i=1.
- WARMUP->MONITOR after DELAY cycles in WARMUP, or after 1 cycle if DELAY=0.
- MONITOR->FAULT on the cycle err_cnt reaches THRESH.
- Any state->IDLE when en_i=0.
REQ-007 Comparison SHALL occur only in MONITOR and FAULT; channel k mismatches when mask_i[k]=1 and aligned a_k != b_k.
REQ-008 mismatch_o SHALL go high one clock after a compare cycle with at least one mismatch, and low otherwise.
REQ-009 err_cnt SHALL increment by 1 per mismatching compare cycle, regardless of how many channels differ, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-010 fault_o SHALL assert in the same cycle as the FSM enters FAULT, and SHALL remain high until clr_i or reset, including while en_i=0.
REQ-011 On the first mismatching cycle since reset or clear, the block SHALL capture the lowest-indexed mismatching channel and its aligned a/b values, and SHALL set first_vld_o one clock later; the capture SHALL hold until clr_i.
REQ-012 clr_i=1 SHALL zero err_cnt, first_vld_o and fault_o, and SHALL force WARMUP if en_i=1, else IDLE.
REQ-013 clr_i SHALL take priority over a simultaneous mismatch, which is dropped.
REQ-014 clr_i or en_i deassertion SHALL flush the delay line, so no stale a-values are compared.
REQ-015 With all mask bits 0, mismatch_o SHALL stay 0 and err_cnt SHALL hold.
REQ-016 With en_i=0, err_cnt and the capture registers SHALL hold their values.

Reset
REQ-017 When rst_i=0, all state SHALL clear immediately, independent of clk_i: FSM=IDLE, delay line=0, and every output=0.
REQ-018 Reset asserted mid-operation SHALL discard any pending mismatch.
REQ-019 After rst_i deasserts, the block SHALL resume on the first clk_i rising edge.

Structure
REQ-020 Package lockstep_pkg SHALL hold the state enum typedef and the parameter defaults.
REQ-021 The a-side alignment SHALL be one sub-module, lockstep_delay, parametrised by WIDTH*CHANNELS and DELAY, with a flush input.
REQ-022 The implementation SHALL contain no latches and no combinational outputs.

Verification
REQ-023 The bench SHALL cover these scenarios (WIDTH=8, CHANNELS=4, DELAY=2, THRESH=3):
- Identical streams, en_i=1, 100 cycles -> err_cnt_o=0, fault_o=0, state_o=2 after 3 cycles.
- b ch2 = a ch2 ^ 8'h01 for one aligned cycle -> mismatch_o pulses 1 cycle; err_cnt_o=1; first_ch_o=2; first_a_o/first_b_o match the injected values.
- Channels 1 and 3 differ in the same cycle -> err_cnt_o +1 only; first_ch_o=1.
- Three mismatching cycles -> fault_o=1 and state_o=3; en_i then dropped -> fault_o stays 1.
- mask_i=4'b1011 with ch2 corrupted -> no mismatch; clr_i coincident with a ch0 mismatch -> err_cnt_o=0 and first_vld_o=0.
- CNT_W=2, continuous mismatch -> err_cnt_o saturates at 3; rst_i pulsed low mid-run -> all outputs 0 without a clock edge.
